// File: rtl/i2c_cfg_pkg.sv
// ---------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared definitions for the camera configuration sequencer.
//   - cfg_state_e        : sequencer state encoding
//   - SRST_REG_ADDR      : sensor register that performs a soft reset (COM7)
//   - HOLE_ENTRY         : LUT value that marks an unused slot to be skipped
//   - DEFAULT_SLAVE_ADDR : OV7670 SCCB write address
//   - CNT_W              : width of the delay counters
//   - isSoftReset()      : recognises a register write that resets the sensor
//   - delayLoad()        : converts a wait length into a counter preload
// ---------------------------------------------------------------------------
package i2c_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PWRUP,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_SRST,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } cfg_state_e;

    localparam logic [7:0]  SRST_REG_ADDR      = 8'h12;
    localparam logic [15:0] HOLE_ENTRY         = 16'h0000;
    localparam logic [7:0]  DEFAULT_SLAVE_ADDR = 8'h42;
    localparam int          CNT_W              = 20;

    // A write to COM7 with bit 7 set resets every sensor register, so the
    // sensor needs a long settle time before it accepts the next write.
    function automatic logic isSoftReset(input logic [7:0] regAddr,
                                         input logic [7:0] regData);
        return (regAddr == SRST_REG_ADDR) && regData[7];
    endfunction

    // A wait state leaves when the counter reads zero, so loading N-1 keeps
    // the state for exactly N cycles. Zero still costs one transit cycle.
    function automatic logic [CNT_W-1:0] delayLoad(input logic [CNT_W-1:0] cycles);
        return (cycles == '0) ? '0 : cycles - CNT_W'(1);
    endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_cnt.sv
// ---------------------------------------------------------------------------
// cfg_delay_cnt
// Loadable down-counter with a zero flag. The sequencer loads it on entry to
// each timed state (power-up, soft-reset settle, inter-write gap) and leaves
// the state once the flag is raised.
//   clk_i      : system clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i this cycle (has priority over counting)
//   load_val_i : preload value
//   zero_o     : count has reached zero
// ---------------------------------------------------------------------------
module cfg_delay_cnt
    import i2c_cfg_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q;

    // Counts down to zero and then parks there until the next load, so the
    // flag stays valid for however long the owning state looks at it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_cfg_sequencer
// Walks an external combinational configuration LUT and issues one I2C/SCCB
// register write per non-empty entry through an external byte-write master.
// It handles the power-up delay, the soft-reset settle time, the gap between
// writes, retry on NACK and done/error reporting.
//   clk, rst       : clock, synchronous active-high reset
//   cfg_start      : start pulse, honoured in IDLE, DONE or ERROR
//   lut_index      : LUT address; lut_data {reg_addr, reg_data}; lut_size
//   i2c_req        : write request, held until i2c_done
//   i2c_dev_addr / i2c_reg_addr / i2c_wr_data : fields of the current write
//   i2c_done       : one-cycle completion pulse; i2c_nack valid with it
//   cfg_busy       : sequence in progress
//   cfg_done       : every entry written (level)
//   cfg_err        : an entry failed after all retries (level); err_index
// ---------------------------------------------------------------------------
module i2c_cfg_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter bit          AUTO_START = 1'b1,
    parameter logic [7:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
    parameter logic [19:0] PWRUP_CYC  = 20'd1000000,
    parameter logic [19:0] SRST_CYC   = 20'd1000000,
    parameter logic [15:0] GAP_CYC    = 16'd500,
    parameter int unsigned MAX_RETRY  = 2
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_start,
    output logic [7:0]  lut_index,
    input  logic [15:0] lut_data,
    input  logic [7:0]  lut_size,
    output logic        i2c_req,
    output logic [7:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic [7:0]  i2c_wr_data,
    input  logic        i2c_done,
    input  logic        i2c_nack,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic [7:0]  err_index
);

    localparam logic [7:0]       MAX_RETRY_W = 8'(MAX_RETRY);
    localparam logic [CNT_W-1:0] PWRUP_LOAD  = delayLoad(PWRUP_CYC);
    localparam logic [CNT_W-1:0] SRST_LOAD   = delayLoad(SRST_CYC);
    localparam logic [CNT_W-1:0] GAP_LOAD    = delayLoad({4'd0, GAP_CYC});

    cfg_state_e       state_q, state_d;
    logic [7:0]       lutIndex_q, lutIndex_d;
    logic [7:0]       regAddr_q, regAddr_d;
    logic [7:0]       wrData_q, wrData_d;
    logic [7:0]       errIndex_q, errIndex_d;
    logic [7:0]       retryCnt_q, retryCnt_d;
    logic             retryPend_q, retryPend_d;
    logic             autoPend_q, autoPend_d;
    logic [7:0]       devAddr_q;
    logic             req_q, busy_q, done_q, err_q;
    logic             cntLoad;
    logic [CNT_W-1:0] cntLoadVal;
    logic             cntZero;

    // One shared delay counter serves every timed state; only one of them
    // can be active at a time.
    cfg_delay_cnt u_delay (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (cntLoad),
        .load_val_i (cntLoadVal),
        .zero_o     (cntZero)
    );

    // Next-state logic. The counter is loaded on the transition into each
    // timed state. retryPend_q remembers that a GAP was entered because of a
    // NACK, so the gap ends by re-issuing the same entry instead of moving on.
    // autoPend_q provides the single automatic start after reset.
    always_comb begin
        state_d     = state_q;
        lutIndex_d  = lutIndex_q;
        regAddr_d   = regAddr_q;
        wrData_d    = wrData_q;
        errIndex_d  = errIndex_q;
        retryCnt_d  = retryCnt_q;
        retryPend_d = retryPend_q;
        autoPend_d  = autoPend_q;
        cntLoad     = 1'b0;
        cntLoadVal  = '0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (cfg_start || ((state_q == ST_IDLE) && autoPend_q)) begin
                    state_d     = ST_PWRUP;
                    lutIndex_d  = 8'd0;
                    retryCnt_d  = 8'd0;
                    retryPend_d = 1'b0;
                    autoPend_d  = 1'b0;
                    cntLoad     = 1'b1;
                    cntLoadVal  = PWRUP_LOAD;
                end
            end
            ST_PWRUP: begin
                if (cntZero) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (lutIndex_q == lut_size) begin
                    state_d = ST_DONE;
                end else if (lut_data == HOLE_ENTRY) begin
                    lutIndex_d = lutIndex_q + 8'd1;
                end else begin
                    regAddr_d = lut_data[15:8];
                    wrData_d  = lut_data[7:0];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (i2c_done) begin
                    if (!i2c_nack) begin
                        retryCnt_d = 8'd0;
                        cntLoad    = 1'b1;
                        if (isSoftReset(regAddr_q, wrData_q)) begin
                            state_d    = ST_SRST;
                            cntLoadVal = SRST_LOAD;
                        end else begin
                            state_d    = ST_GAP;
                            cntLoadVal = GAP_LOAD;
                        end
                    end else if (retryCnt_q < MAX_RETRY_W) begin
                        retryCnt_d  = retryCnt_q + 8'd1;
                        retryPend_d = 1'b1;
                        state_d     = ST_GAP;
                        cntLoad     = 1'b1;
                        cntLoadVal  = GAP_LOAD;
                    end else begin
                        errIndex_d = lutIndex_q;
                        state_d    = ST_ERROR;
                    end
                end
            end
            ST_SRST: begin
                if (cntZero) begin
                    lutIndex_d = lutIndex_q + 8'd1;
                    state_d    = ST_FETCH;
                end
            end
            ST_GAP: begin
                if (cntZero) begin
                    if (retryPend_q) begin
                        retryPend_d = 1'b0;
                        state_d     = ST_ISSUE;
                    end else begin
                        lutIndex_d = lutIndex_q + 8'd1;
                        state_d    = ST_FETCH;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Status outputs are decoded from the next
    // state so they change on the same edge as the state itself, which keeps
    // every output registered without adding a cycle of lag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lutIndex_q  <= 8'd0;
            regAddr_q   <= 8'd0;
            wrData_q    <= 8'd0;
            errIndex_q  <= 8'd0;
            retryCnt_q  <= 8'd0;
            retryPend_q <= 1'b0;
            autoPend_q  <= AUTO_START;
            devAddr_q   <= SLAVE_ADDR;
            req_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lutIndex_q  <= lutIndex_d;
            regAddr_q   <= regAddr_d;
            wrData_q    <= wrData_d;
            errIndex_q  <= errIndex_d;
            retryCnt_q  <= retryCnt_d;
            retryPend_q <= retryPend_d;
            autoPend_q  <= autoPend_d;
            devAddr_q   <= SLAVE_ADDR;
            req_q       <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
            busy_q      <= (state_d != ST_IDLE) && (state_d != ST_DONE) &&
                           (state_d != ST_ERROR);
            done_q      <= (state_d == ST_DONE);
            err_q       <= (state_d == ST_ERROR);
        end
    end

    assign lut_index    = lutIndex_q;
    assign i2c_req      = req_q;
    assign i2c_dev_addr = devAddr_q;
    assign i2c_reg_addr = regAddr_q;
    assign i2c_wr_data  = wrData_q;
    assign cfg_busy     = busy_q;
    assign cfg_done     = done_q;
    assign cfg_err      = err_q;
    assign err_index    = errIndex_q;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_cfg_sequencer
// Drives the sequencer with a stub LUT and a stub I2C master. A reference
// model walks the LUT from the rules of the sequence and queues the expected
// writes (fields plus idle cycles before each one) along with the ACK/NACK
// answer the stub master gives for each attempt. A monitor pops the queue on
// every new request.
// ---------------------------------------------------------------------------
module tb_i2c_cfg_sequencer;

    localparam logic [19:0] PWRUP = 20'd10;
    localparam logic [19:0] SRST  = 20'd20;
    localparam logic [15:0] GAP   = 16'd3;
    localparam int          MAXR  = 2;

    typedef struct {
        logic [23:0] fields;
        int          gap;
    } expWrite_t;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic [7:0]  lut_size;
    logic        i2c_req;
    logic [7:0]  i2c_dev_addr;
    logic [7:0]  i2c_reg_addr;
    logic [7:0]  i2c_wr_data;
    logic        i2c_done;
    logic        i2c_nack;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic [7:0]  err_index;

    logic [15:0] lutMem [256];
    int          nackPlan [256];
    expWrite_t   expQ[$];
    bit          nackQ[$];
    bit          monitorOn;
    int          checks;
    int          errors;

    i2c_cfg_sequencer #(
        .AUTO_START (1'b1),
        .SLAVE_ADDR (8'h42),
        .PWRUP_CYC  (PWRUP),
        .SRST_CYC   (SRST),
        .GAP_CYC    (GAP),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .lut_index    (lut_index),
        .lut_data     (lut_data),
        .lut_size     (lut_size),
        .i2c_req      (i2c_req),
        .i2c_dev_addr (i2c_dev_addr),
        .i2c_reg_addr (i2c_reg_addr),
        .i2c_wr_data  (i2c_wr_data),
        .i2c_done     (i2c_done),
        .i2c_nack     (i2c_nack),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .err_index    (err_index)
    );

    assign lut_data = lutMem[lut_index];

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Stub I2C master: answers a request five cycles after it appears with a
    // done pulse, taking the ACK/NACK answer from the model's queue. A
    // withdrawn request restarts the count.
    initial begin : stubMaster
        int cnt;
        cnt      = 0;
        i2c_done = 1'b0;
        i2c_nack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (i2c_req === 1'b1) begin
                cnt++;
                if (cnt == 5) begin
                    i2c_done = 1'b1;
                    i2c_nack = (nackQ.size() > 0) ? nackQ.pop_front() : 1'b0;
                end else begin
                    i2c_done = 1'b0;
                    i2c_nack = 1'b0;
                end
            end else begin
                cnt      = 0;
                i2c_done = 1'b0;
                i2c_nack = 1'b0;
            end
        end
    end

    // Monitor: every rising request is one write attempt and is compared
    // against the head of the expected queue, including the idle cycles
    // since the previous request. Fields must still match at done time.
    initial begin : monitor
        bit          prevReq;
        int          lowCnt;
        logic [23:0] curFields;
        expWrite_t   e;
        prevReq   = 1'b0;
        lowCnt    = 0;
        curFields = '0;
        forever begin
            @(negedge clk);
            if (!monitorOn || rst !== 1'b0) begin
                prevReq = 1'b0;
                lowCnt  = 0;
            end else begin
                curFields = (i2c_req === 1'b1 && !prevReq) ?
                            {i2c_dev_addr, i2c_reg_addr, i2c_wr_data} : curFields;
                if (i2c_req === 1'b1 && !prevReq) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_write got=%h required=none", curFields);
                    end else begin
                        e = expQ.pop_front();
                        if (curFields !== e.fields) begin
                            errors++;
                            $display("[TB] FAIL write_fields got=%h required=%h", curFields, e.fields);
                        end
                        if (e.gap >= 0) begin
                            checks++;
                            if (lowCnt != e.gap) begin
                                errors++;
                                $display("[TB] FAIL write_gap got=%0d required=%0d", lowCnt, e.gap);
                            end
                        end
                    end
                end
                if (i2c_req === 1'b1 && i2c_done === 1'b1) begin
                    checks++;
                    if ({i2c_dev_addr, i2c_reg_addr, i2c_wr_data} !== curFields) begin
                        errors++;
                        $display("[TB] FAIL field_hold got=%h required=%h",
                                 {i2c_dev_addr, i2c_reg_addr, i2c_wr_data}, curFields);
                    end
                end
                lowCnt  = (i2c_req === 1'b1) ? 0 : lowCnt + 1;
                prevReq = (i2c_req === 1'b1);
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    // Reference model: walk the LUT in order, skip holes, try each entry up
    // to MAXR+1 times, and record the idle cycles expected before each
    // request (gap or settle time, one FETCH per entry visited, no FETCH
    // before a retry).
    task automatic buildModel(output bit expErr, output int expErrIdx);
        int          pendingGap;
        expWrite_t   w;
        bit          nackBit;
        logic [15:0] e;
        expErr     = 1'b0;
        expErrIdx  = 0;
        pendingGap = -1;
        for (int i = 0; i < int'(lut_size); i++) begin
            e = lutMem[i];
            if (e == 16'h0000) begin
                if (pendingGap >= 0) pendingGap++;
                continue;
            end
            for (int a = 0; a <= MAXR; a++) begin
                nackBit  = (a < nackPlan[i]);
                w.fields = {8'h42, e};
                w.gap    = pendingGap;
                expQ.push_back(w);
                nackQ.push_back(nackBit);
                if (!nackBit) begin
                    pendingGap = ((e[15:8] == 8'h12) && e[7]) ? int'(SRST) + 1 : int'(GAP) + 1;
                    break;
                end
                if (a == MAXR) begin
                    expErr    = 1'b1;
                    expErrIdx = i;
                    return;
                end
                pendingGap = int'(GAP);
            end
        end
    endtask

    task automatic loadDirectedLut();
        for (int i = 0; i < 256; i++) begin
            lutMem[i]   = 16'h0000;
            nackPlan[i] = 0;
        end
        lutMem[0] = 16'h1280;
        lutMem[1] = 16'h3a04;
        lutMem[2] = 16'h0000;
        lutMem[3] = 16'h1713;
        lut_size  = 8'd4;
    endtask

    task automatic loadRandomLut();
        int r;
        for (int i = 0; i < 256; i++) begin
            lutMem[i]   = 16'h0000;
            nackPlan[i] = 0;
        end
        lut_size = 8'($urandom_range(0, 12));
        for (int i = 0; i < int'(lut_size); i++) begin
            r = $urandom_range(0, 99);
            if (r < 20)      lutMem[i] = 16'h0000;
            else if (r < 30) lutMem[i] = 16'h1280;
            else             lutMem[i] = 16'($urandom_range(0, 65535));
            r = $urandom_range(0, 99);
            nackPlan[i] = (r < 70) ? 0 : (r < 85) ? 1 : (r < 96) ? 2 : 3;
        end
    endtask

    task automatic waitFinish(input bit expErr, input int expErrIdx);
        int n;
        n = 0;
        while (cfg_done !== 1'b1 && cfg_err !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("finish_in_time", 32'(n < 20000), 32'd1);
        checkOutput("cfg_done", cfg_done, 32'(!expErr));
        checkOutput("cfg_err", cfg_err, 32'(expErr));
        if (expErr) checkOutput("err_index", err_index, 32'(expErrIdx));
        repeat (30) @(negedge clk);
        checkOutput("req_idle", i2c_req, 32'd0);
        checkOutput("busy_idle", cfg_busy, 32'd0);
        checkOutput("writes_left", 32'(expQ.size()), 32'd0);
    endtask

    task automatic runScenario(input bit pokeGap);
        bit  expErr;
        int  expErrIdx;
        int  falls;
        int  n;
        bit  prev;
        buildModel(expErr, expErrIdx);
        applyStimulus();
        checkOutput("start_done_clr", cfg_done, 32'd0);
        checkOutput("start_err_clr", cfg_err, 32'd0);
        checkOutput("start_busy", cfg_busy, 32'd1);
        checkOutput("start_index", lut_index, 32'd0);
        if (pokeGap) begin
            falls = 0;
            n     = 0;
            prev  = 1'b0;
            while (falls < 2 && n < 5000) begin
                @(negedge clk);
                if (prev && i2c_req !== 1'b1) falls++;
                prev = (i2c_req === 1'b1);
                n++;
            end
            checkOutput("reach_gap", 32'(falls), 32'd2);
            applyStimulus();
            checkOutput("busy_after_poke", cfg_busy, 32'd1);
        end
        waitFinish(expErr, expErrIdx);
    endtask

    // Main sequence.
    initial begin
        bit expErr;
        int expErrIdx;
        int n;
        checks    = 0;
        errors    = 0;
        monitorOn = 1'b0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        loadDirectedLut();
        lut_size = 8'd0;

        $display("[TB] reset values");
        repeat (3) @(negedge clk);
        checkOutput("rst_lut_index", lut_index, 32'd0);
        checkOutput("rst_req", i2c_req, 32'd0);
        checkOutput("rst_dev_addr", i2c_dev_addr, 32'h42);
        checkOutput("rst_reg_addr", i2c_reg_addr, 32'd0);
        checkOutput("rst_wr_data", i2c_wr_data, 32'd0);
        checkOutput("rst_busy", cfg_busy, 32'd0);
        checkOutput("rst_done", cfg_done, 32'd0);
        checkOutput("rst_err", cfg_err, 32'd0);
        checkOutput("rst_err_index", err_index, 32'd0);

        $display("[TB] empty LUT after auto start");
        buildModel(expErr, expErrIdx);
        monitorOn = 1'b1;
        rst = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) checkOutput("auto_busy", cfg_busy, 32'd1);
        end while (cfg_done !== 1'b1 && n < 100);
        checkOutput("empty_done_cycles", 32'(n), 32'(int'(PWRUP) + 2));
        waitFinish(expErr, expErrIdx);

        $display("[TB] directed LUT, start pulse ignored during gap");
        loadDirectedLut();
        runScenario(1'b1);

        $display("[TB] directed LUT, NACK twice on entry 1");
        loadDirectedLut();
        nackPlan[1] = 2;
        runScenario(1'b0);

        $display("[TB] directed LUT, NACK three times on entry 1");
        loadDirectedLut();
        nackPlan[1] = 3;
        runScenario(1'b0);

        $display("[TB] randomized LUTs");
        for (int k = 0; k < 8; k++) begin
            loadRandomLut();
            runScenario(1'b0);
        end

        $display("[TB] reset during a write");
        loadDirectedLut();
        buildModel(expErr, expErrIdx);
        applyStimulus();
        n = 0;
        while (i2c_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("req_seen", i2c_req, 32'd1);
        monitorOn = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_req", i2c_req, 32'd0);
        checkOutput("rst_mid_index", lut_index, 32'd0);
        checkOutput("rst_mid_busy", cfg_busy, 32'd0);
        repeat (2) @(negedge clk);
        expQ.delete();
        nackQ.delete();
        buildModel(expErr, expErrIdx);
        monitorOn = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("restart_busy", cfg_busy, 32'd1);
        checkOutput("restart_index", lut_index, 32'd0);
        waitFinish(expErr, expErrIdx);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
